if_fetch_stage: RTL and testbench

Parametrised instruction-fetch stage for the pipelined MIPS core, successor to the plain IF block. It holds the PC register and drives the instruction-memory address. It detects fetch address errors and has an integrated IF/ID pipeline register. It supports stall, exception redirect, ERET redirect and delay-slot (BD) tracking, and sits between the branch/NPC unit and the ID stage.

---
 rtl/if_fetch_stage_pkg.sv | 20 ++
 rtl/if_fetch_stage_if.sv | 18 +
 rtl/if_fetch_stage_if_id_reg.sv | 52 +++++
 rtl/if_fetch_stage.sv | 95 +++++++++
 tb/tb_if_fetch_stage.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
// Exception codes and default address map of the fetch unit.
package if_fetch_stage_pkg;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  localparam logic [31:0] DEF_PC_RESET    = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_BASE     = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_LIMIT    = 32'h0000_6FFC;
  localparam logic [31:0] DEF_EXC_HANDLER = 32'h0000_4180;

  // Misaligned or outside [base, limit] (unsigned, limit inclusive).
  function automatic logic addr_error(input logic [31:0] pc,
                                      input logic [31:0] base,
                                      input logic [31:0] limit);
    return (pc[1:0] != 2'b00) || (pc < base) || (pc > limit);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
// Combinational read: rdata follows addr in the same cycle.
interface if_fetch_stage_if;

  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;

  modport master (
    output i_inst_addr,
    input  i_inst_rdata
  );

  modport slave (
    input  i_inst_addr,
    output i_inst_rdata
  );

endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush (bubble) beats load, load beats hold.
// A flush carries the redirect target into the PC field with no instruction.
module if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = DEF_PC_RESET
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        load,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [4:0]  exc_code,
  input  logic        bd,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [4:0]  id_exc_code,
  output logic        id_bd
);

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [4:0]  exc_q;
  logic        bd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= PC_RESET;
      instr_q <= 32'h0;
      exc_q   <= EXC_NONE;
      bd_q    <= 1'b0;
    end else if (flush) begin
      pc_q    <= flush_pc;
      instr_q <= 32'h0;
      exc_q   <= EXC_NONE;
      bd_q    <= 1'b0;
    end else if (load) begin
      pc_q    <= pc;
      instr_q <= instr;
      exc_q   <= exc_code;
      bd_q    <= bd;
    end
  end

  assign id_pc       = pc_q;
  assign id_instr    = instr_q;
  assign id_exc_code = exc_q;
  assign id_bd       = bd_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, fetch address check, IF/ID register
// and a count of instructions accepted into ID.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET    = DEF_PC_RESET,
  parameter logic [31:0] IM_BASE     = DEF_IM_BASE,
  parameter logic [31:0] IM_LIMIT    = DEF_IM_LIMIT,
  parameter logic [31:0] EXC_HANDLER = DEF_EXC_HANDLER,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enablePC,
  input  logic [31:0]      NPC,
  input  logic             is_branch_ID,
  input  logic             req,
  input  logic             eret,
  input  logic [31:0]      epc,
  if_fetch_stage_if.master imem,
  output logic [31:0]      IF_PC,
  output logic [31:0]      IF_instr,
  output logic [31:0]      ID_PC,
  output logic [31:0]      ID_instr,
  output logic [4:0]       ID_excCode,
  output logic             ID_BD,
  output logic [CNT_W-1:0] fetch_count
);

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             adel;
  logic [4:0]       if_exc_code;
  logic             flush;
  logic [31:0]      flush_pc;

  // req outranks eret; both outrank the stall.
  assign flush    = req | eret;
  assign flush_pc = req ? EXC_HANDLER : epc;

  always_comb begin
    pc_d = pc_q;
    if (req) begin
      pc_d = EXC_HANDLER;
    end else if (eret) begin
      pc_d = epc;
    end else if (enablePC) begin
      pc_d = NPC;
    end
  end

  always_comb begin
    count_d = count_q;
    if (enablePC && !flush) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= PC_RESET;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign adel        = addr_error(pc_q, IM_BASE, IM_LIMIT);
  assign if_exc_code = adel ? EXC_ADEL : EXC_NONE;

  assign imem.i_inst_addr = pc_q;
  assign IF_PC            = pc_q;
  assign IF_instr         = adel ? 32'h0 : imem.i_inst_rdata;
  assign fetch_count      = count_q;

  if_id_reg #(
    .PC_RESET (PC_RESET)
  ) u_if_id_reg (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .load        (enablePC),
    .pc          (pc_q),
    .instr       (IF_instr),
    .exc_code    (if_exc_code),
    .bd          (is_branch_ID),
    .id_pc       (ID_PC),
    .id_instr    (ID_instr),
    .id_exc_code (ID_excCode),
    .id_bd       (ID_BD)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a spec-level model pushes expected
// post-edge state to a queue, which is popped and checked after each edge.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  localparam logic [31:0] P_RESET = 32'h0000_3000;
  localparam logic [31:0] P_BASE  = 32'h0000_3000;
  localparam logic [31:0] P_LIMIT = 32'h0000_6FFC;
  localparam logic [31:0] P_EXC   = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enablePC = 1'b0;
  logic [31:0] NPC = 32'h0;
  logic        is_branch_ID = 1'b0;
  logic        req = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc = 32'h0;
  logic [31:0] IF_PC, IF_instr, ID_PC, ID_instr, fetch_count;
  logic [4:0]  ID_excCode;
  logic        ID_BD;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0BAD_F00D;
  endfunction

  if_fetch_stage_if imem_bus ();
  assign imem_bus.i_inst_rdata = mem_word(imem_bus.i_inst_addr);

  if_fetch_stage #(
    .PC_RESET    (P_RESET),
    .IM_BASE     (P_BASE),
    .IM_LIMIT    (P_LIMIT),
    .EXC_HANDLER (P_EXC),
    .CNT_W       (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enablePC     (enablePC),
    .NPC          (NPC),
    .is_branch_ID (is_branch_ID),
    .req          (req),
    .eret         (eret),
    .epc          (epc),
    .imem         (imem_bus),
    .IF_PC        (IF_PC),
    .IF_instr     (IF_instr),
    .ID_PC        (ID_PC),
    .ID_instr     (ID_instr),
    .ID_excCode   (ID_excCode),
    .ID_BD        (ID_BD),
    .fetch_count  (fetch_count)
  );

  typedef struct packed {
    logic [31:0] if_pc;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [4:0]  id_exc;
    logic        id_bd;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  logic [31:0] m_pc, m_id_pc, m_id_instr, m_cnt;
  logic [4:0]  m_id_exc;
  logic        m_id_bd;

  task automatic chk(input string tag, input string fld, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s.%s: observed %h expected %h", tag, fld, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc       = P_RESET;
    m_id_pc    = P_RESET;
    m_id_instr = 32'h0;
    m_id_exc   = 5'd0;
    m_id_bd    = 1'b0;
    m_cnt      = 32'h0;
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.if_pc    = m_pc;
    e.id_pc    = m_id_pc;
    e.id_instr = m_id_instr;
    e.id_exc   = m_id_exc;
    e.id_bd    = m_id_bd;
    e.cnt      = m_cnt;
    return e;
  endfunction

  task automatic check_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s.queue: observed empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, "IF_PC", IF_PC, e.if_pc);
      chk(tag, "ID_PC", ID_PC, e.id_pc);
      chk(tag, "ID_instr", ID_instr, e.id_instr);
      chk(tag, "ID_excCode", {27'h0, ID_excCode}, {27'h0, e.id_exc});
      chk(tag, "ID_BD", {31'h0, ID_BD}, {31'h0, e.id_bd});
      chk(tag, "fetch_count", fetch_count, e.cnt);
    end
  endtask

  // Drive one cycle of inputs, check the IF side, then check state after the edge.
  task automatic step(input string tag, input logic en, input logic [31:0] npc,
                      input logic br, input logic rq, input logic er,
                      input logic [31:0] ep);
    logic        adel;
    logic [31:0] ifi;
    logic [4:0]  code;
    enablePC     = en;
    NPC          = npc;
    is_branch_ID = br;
    req          = rq;
    eret         = er;
    epc          = ep;
    adel = (m_pc[1:0] != 2'b00) || (m_pc < P_BASE) || (m_pc > P_LIMIT);
    ifi  = adel ? 32'h0 : mem_word(m_pc);
    code = adel ? 5'd4 : 5'd0;
    #1;
    chk(tag, "i_inst_addr", imem_bus.i_inst_addr, m_pc);
    chk(tag, "IF_instr", IF_instr, ifi);
    if (rq) begin
      m_id_pc = P_EXC; m_id_instr = 32'h0; m_id_exc = 5'd0; m_id_bd = 1'b0;
      m_pc    = P_EXC;
    end else if (er) begin
      m_id_pc = ep; m_id_instr = 32'h0; m_id_exc = 5'd0; m_id_bd = 1'b0;
      m_pc    = ep;
    end else if (en) begin
      m_id_pc = m_pc; m_id_instr = ifi; m_id_exc = code; m_id_bd = br;
      m_pc    = npc;
      m_cnt   = m_cnt + 32'd1;
    end
    sb.push_back(model_snapshot());
    @(posedge clk);
    #1;
    check_front(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    sb.push_back(model_snapshot());
    check_front("reset");
    reset = 1'b0;

    // Sequential fetch
    step("seq0", 1'b1, 32'h3004, 1'b0, 1'b0, 1'b0, 32'h0);
    step("seq1", 1'b1, 32'h3008, 1'b0, 1'b0, 1'b0, 32'h0);
    step("seq2", 1'b1, 32'h300C, 1'b0, 1'b0, 1'b0, 32'h0);

    // Stall at 300C, then resume
    step("stall0", 1'b0, 32'h3010, 1'b0, 1'b0, 1'b0, 32'h0);
    step("stall1", 1'b0, 32'h3010, 1'b0, 1'b0, 1'b0, 32'h0);
    step("resume", 1'b1, 32'h3010, 1'b0, 1'b0, 1'b0, 32'h0);

    // Exception redirect over a stall; req beats eret
    step("req", 1'b0, 32'h3014, 1'b0, 1'b1, 1'b0, 32'h0);
    step("req_eret", 1'b0, 32'h4184, 1'b0, 1'b1, 1'b1, 32'h3020);

    // ERET redirect, then the return target loads into ID
    step("eret", 1'b1, 32'h4188, 1'b0, 1'b0, 1'b1, 32'h3020);
    step("after_eret", 1'b1, 32'h3024, 1'b0, 1'b0, 1'b0, 32'h0);

    // Address errors: misaligned, above limit, below base; limit itself is legal
    step("to_3002", 1'b1, 32'h3002, 1'b0, 1'b0, 1'b0, 32'h0);
    step("to_7000", 1'b1, 32'h7000, 1'b0, 1'b0, 1'b0, 32'h0);
    step("to_6ffc", 1'b1, 32'h6FFC, 1'b0, 1'b0, 1'b0, 32'h0);
    step("to_2ffc", 1'b1, 32'h2FFC, 1'b0, 1'b0, 1'b0, 32'h0);
    step("to_3000", 1'b1, 32'h3000, 1'b0, 1'b0, 1'b0, 32'h0);

    // Delay-slot tracking: branch in ID at 3004 marks 3008 as BD
    step("br0", 1'b1, 32'h3004, 1'b0, 1'b0, 1'b0, 32'h0);
    step("br1", 1'b1, 32'h3008, 1'b0, 1'b0, 1'b0, 32'h0);
    step("br_ds", 1'b1, 32'h300C, 1'b1, 1'b0, 1'b0, 32'h0);
    step("br_after", 1'b1, 32'h3010, 1'b0, 1'b0, 1'b0, 32'h0);

    // Asynchronous reset in mid-cycle
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    sb.push_back(model_snapshot());
    check_front("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post_reset", 1'b1, 32'h3004, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
